// File: rtl/user_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// user_uart_tx_fifo
//   8N1 UART transmitter fed by a small write FIFO. Bytes pushed on the
//   valid/ready interface are queued, then serialised LSB first with one
//   start bit and one stop bit. One bit lasts BAUD_CNT+1 mclk cycles.
//   Back-to-back queued bytes leave no idle gap between frames.
//
// Ports
//   mclk        in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   tx_data     in   byte to send
//   tx_valid    in   tx_data offered this cycle
//   tx_ready    out  FIFO has room; a push happens on tx_valid & tx_ready
//   uart_tx     out  serial line, idle high, driven from a flop
//   tx_busy     out  a frame is on the line or the FIFO holds data
//   fifo_level  out  number of queued bytes (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module user_uart_tx_fifo #(
  parameter int BAUD_CNT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DIV_W = (BAUD_CNT > 0) ? $clog2(BAUD_CNT + 1) : 1;
  localparam int LVL_W = FIFO_AW + 1;
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BAUD_CNT);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [2:0]         bit_r, bit_s;
  logic [7:0]         shift_r, shift_s;
  logic               tx_r, tx_s;
  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]   level_r, level_s;
  logic               push_s, pop_s, div_tc_s, fifo_ne_s;

  assign fifo_ne_s  = (level_r != LVL_ZERO);
  assign tx_ready   = (level_r != LVL_FULL);
  assign push_s     = tx_valid & tx_ready;
  assign div_tc_s   = (div_r == DIV_TC);
  assign uart_tx    = tx_r;
  assign fifo_level = level_r;
  assign tx_busy    = (state_r != ST_IDLE) | fifo_ne_s;

  // Next-state logic for the serialiser; the shift register is consumed from
  // bit 0 so the bit on the line is always shift_r[0] at a bit boundary.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fifo_ne_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          div_s   = DIV_ZERO;
          tx_s    = 1'b0;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (div_tc_s) begin
          tx_s    = shift_r[0];
          shift_s = {1'b0, shift_r[7:1]};
          bit_s   = 3'd0;
          div_s   = DIV_ZERO;
          state_s = ST_DATA;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (div_tc_s) begin
          div_s = DIV_ZERO;
          if (bit_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = ST_STOP;
          end else begin
            tx_s    = shift_r[0];
            shift_s = {1'b0, shift_r[7:1]};
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (div_tc_s) begin
          div_s = DIV_ZERO;
          // Chain straight into the next start bit when more data is queued.
          if (fifo_ne_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            tx_s    = 1'b0;
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        div_s   = DIV_ZERO;
        tx_s    = 1'b1;
      end
    endcase
  end

  // FIFO occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    level_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_W'(1);
      2'b01:   level_s = level_r - LVL_W'(1);
      default: level_s = level_r;
    endcase
  end

  // Control and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      div_r    <= DIV_ZERO;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
      wr_ptr_r <= FIFO_AW'(0);
      rd_ptr_r <= FIFO_AW'(0);
      level_r  <= LVL_ZERO;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      level_r <= level_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge mclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

endmodule

// File: tb/tb_user_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_user_uart_tx_fifo
//   Bench for user_uart_tx_fifo. A queue-based model predicts the line and
//   FIFO flags each cycle; a sampling receiver decodes the line into bytes.
//   A second instance with a slow divider covers long bit periods.
// ---------------------------------------------------------------------------
module tb_user_uart_tx_fifo;

  localparam int P1    = 2;   // cycles per bit for the main instance
  localparam int DEPTH = 4;

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, tx_busy;
  logic [2:0] fifo_level;

  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, uart_tx2, tx_busy2;
  logic [2:0] fifo_level2;

  user_uart_tx_fifo #(.BAUD_CNT(1), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .mclk(mclk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );

  user_uart_tx_fifo #(.BAUD_CNT(9), .FIFO_DEPTH(4), .FIFO_AW(2)) dut_slow (
    .mclk(mclk), .reset_n(reset_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .uart_tx(uart_tx2), .tx_busy(tx_busy2), .fifo_level(fifo_level2)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: queued bytes and the remaining line levels of the current frame
  logic [7:0] mq[$];
  bit         mw[$];
  logic       exp_tx = 1'b1;
  logic       exp_busy = 1'b0;
  int         exp_level = 0;
  logic [7:0] acc_log[$];
  int         fill_cnt = 0;
  int         both_cnt = 0;

  // receiver and run statistics
  logic [7:0] rx_log[$];
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  int         busy_cycles = 0;
  int         max_level = 0;
  bit         saw_not_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    mw.delete();
    exp_tx    = 1'b1;
    exp_busy  = 1'b0;
    exp_level = 0;
  endtask

  // One clock edge of the reference: pop-then-push ordering, frame expanded to levels.
  task automatic model_step();
    bit         acc;
    bit         popped;
    bit         in_frame;
    logic [7:0] b;
    if (!reset_n) begin
      model_clear();
      return;
    end
    acc    = tx_valid && (mq.size() != DEPTH);
    popped = 1'b0;
    if (mw.size() == 0 && mq.size() != 0) begin
      b = mq.pop_front();
      popped = 1'b1;
      for (int k = 0; k < 10; k++)
        for (int r = 0; r < P1; r++)
          mw.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]));
    end
    if (acc) begin
      mq.push_back(tx_data);
      acc_log.push_back(tx_data);
      if (mq.size() == DEPTH) fill_cnt++;
    end
    if (acc && popped) both_cnt++;
    in_frame  = (mw.size() != 0);
    exp_tx    = in_frame ? mw.pop_front() : 1'b1;
    exp_busy  = in_frame || (mq.size() != 0);
    exp_level = mq.size();
  endtask

  task automatic tick();
    @(posedge mclk);
    model_step();
    @(negedge mclk);
    if (reset_n) begin
      chk("line", uart_tx, exp_tx);
      chk("level", fifo_level, exp_level);
      chk("ready", tx_ready, exp_level != DEPTH);
      chk("busy", tx_busy, exp_busy);
    end
    if (tx_busy) busy_cycles++;
    if (int'(fifo_level) > max_level) max_level = fifo_level;
    if (!tx_ready) saw_not_ready = 1'b1;
    if (!reset_n) rx_busy = 1'b0;
    else if (!rx_busy) begin
      if (uart_tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % P1 == 0 && rx_cnt >= P1 && rx_cnt <= 8 * P1) rx_byte[rx_cnt / P1 - 1] = uart_tx;
      if (rx_cnt == 9 * P1 && uart_tx === 1'b1) rx_log.push_back(rx_byte);
      if (rx_cnt == 10 * P1 - 1) rx_busy = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (tx_busy && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", tx_busy, 1'b0);
  endtask

  task automatic push_seq(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] got;
    logic [7:0]  t2_exp [4];
    logic [9:0]  lows;
    int          rxb, idx, highs, busy2, fb, bb, ab, nrx;
    bit          acc_now;
    logic        line2 [105];
    logic        bz2 [105];

    // reset state
    repeat (3) @(negedge mclk);
    chk("rst_line", uart_tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_line2", uart_tx2, 1'b1);
    chk("rst_level2", fifo_level2, 3'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // single byte 0x55: waveform and latency
    busy_cycles = 0;
    rxb = rx_log.size();
    push_seq(8'h55);
    chk("t1_level_after_push", fifo_level, 3'd1);
    chk("t1_line_before_pop", uart_tx, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      got[19-i] = uart_tx;
      if (i == 0) chk("t1_level_after_pop", fifo_level, 3'd0);
    end
    chk("t1_wave", got, 20'b00110011001100110011);
    wait_idle(50);
    chk("t1_busy_cycles", busy_cycles, 21);
    chk("t1_rx_count", rx_log.size(), rxb + 1);
    if (rx_log.size() > rxb) chk("t1_rx_byte", rx_log[rxb], 8'h55);

    // four consecutive pushes "ABC\n"
    t2_exp[0] = 8'h41; t2_exp[1] = 8'h42; t2_exp[2] = 8'h43; t2_exp[3] = 8'h0A;
    busy_cycles = 0; max_level = 0; saw_not_ready = 1'b0;
    rxb = rx_log.size();
    for (int i = 0; i < 4; i++) begin
      tx_data  = t2_exp[i];
      tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(200);
    chk("t2_ready_stayed", saw_not_ready, 1'b0);
    chk("t2_peak_level", max_level, 3);
    chk("t2_busy_cycles", busy_cycles, 81);
    chk("t2_rx_count", rx_log.size(), rxb + 4);
    for (int i = 0; i < 4; i++)
      if (rx_log.size() > rxb + i) chk("t2_rx_byte", rx_log[rxb+i], t2_exp[i]);

    // hold valid across six bytes: FIFO fills and backpressures
    max_level = 0; saw_not_ready = 1'b0;
    rxb = rx_log.size();
    idx = 0;
    for (int n = 0; n < 300 && idx < 6; n++) begin
      tx_data  = 8'h30 + 8'(idx);
      tx_valid = 1'b1;
      acc_now  = tx_ready;
      tick();
      if (acc_now) idx++;
    end
    tx_valid = 1'b0;
    chk("t3_all_accepted", idx, 6);
    wait_idle(300);
    chk("t3_saw_not_ready", saw_not_ready, 1'b1);
    chk("t3_peak_level", max_level, 4);
    chk("t3_rx_count", rx_log.size(), rxb + 6);
    for (int i = 0; i < 6; i++)
      if (rx_log.size() > rxb + i) chk("t3_rx_byte", rx_log[rxb+i], 8'h30 + 8'(i));

    // randomized bursts and lulls: wrap, full, push+pop together
    fb = fill_cnt; bb = both_cnt; ab = acc_log.size();
    rxb = rx_log.size();
    for (int c = 0; c < 1200; c++) begin
      if ((c / 150) % 2 == 0) tx_valid = ($urandom_range(0, 99) < 70);
      else tx_valid = ($urandom_range(0, 99) < 3);
      tx_data = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(300);
    chk("t4_fills_ge3", (fill_cnt - fb) >= 3, 1'b1);
    chk("t4_push_pop_seen", (both_cnt - bb) > 0, 1'b1);
    nrx = rx_log.size() - rxb;
    chk("t4_rx_count", nrx, acc_log.size() - ab);
    for (int i = 0; i < nrx && ab + i < acc_log.size(); i++)
      chk("t4_rx_byte", rx_log[rxb+i], acc_log[ab+i]);

    // slow divider: 0xFF frame on the second instance
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    chk("t6_level_after_push", fifo_level2, 3'd1);
    chk("t6_line_before_pop", uart_tx2, 1'b1);
    chk("t6_busy_after_push", tx_busy2, 1'b1);
    for (int i = 0; i < 105; i++) begin
      tick();
      line2[i] = uart_tx2;
      bz2[i]   = tx_busy2;
    end
    highs = 0; busy2 = 0;
    for (int i = 0; i < 105; i++) begin
      if (i < 10) lows[i] = line2[i];
      else if (line2[i] === 1'b1) highs++;
      if (bz2[i] === 1'b1) busy2++;
    end
    chk("t6_start_low", lows, 10'h000);
    chk("t6_high_after_start", highs, 95);
    chk("t6_busy_count", busy2, 100);
    chk("t6_busy_last", bz2[99], 1'b1);
    chk("t6_busy_fall", bz2[100], 1'b0);

    // reset in the middle of a frame with bytes queued
    rxb = rx_log.size();
    push_seq(8'hA5);
    push_seq(8'h11);
    push_seq(8'h22);
    repeat (6) tick();
    chk("t5_queued", fifo_level, 3'd2);
    chk("t5_busy_before", tx_busy, 1'b1);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("t5_line_async", uart_tx, 1'b1);
    chk("t5_level_async", fifo_level, 3'd0);
    chk("t5_busy_async", tx_busy, 1'b0);
    chk("t5_ready_async", tx_ready, 1'b1);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    chk("t5_idle_busy", tx_busy, 1'b0);
    chk("t5_idle_line", uart_tx, 1'b1);
    chk("t5_no_rx", rx_log.size(), rxb);
    push_seq(8'h5A);
    wait_idle(60);
    chk("t5_rx_count_after", rx_log.size(), rxb + 1);
    if (rx_log.size() > rxb) chk("t5_rx_after", rx_log[rxb], 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
